decode: RTL

- LC-3 decode stage, directly downstream of `fetch`.
- After the controller starts a decode, waits for the instruction word at `fetch`'s `addr_out`, then latches it into the instruction register (IR).
- Splits the IR into register-file, ALU and memory-stage fields.
- Returns `opcode_out`, `offset_out` and `br_nzp_out` to `fetch` (its `opCode_in`, `offset_in`, `br_nzp`) for next-PC computation.

---
 rtl/lc3_pkg.sv | 26 ++
 rtl/sext.sv | 11 +
 rtl/decode.sv | 82 ++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcode values and the decode stage state encoding.
package lc3_pkg;

  localparam logic [3:0] OP_BR   = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_LD   = 4'd2;
  localparam logic [3:0] OP_ST   = 4'd3;
  localparam logic [3:0] OP_JSR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_LDR  = 4'd6;
  localparam logic [3:0] OP_STR  = 4'd7;
  localparam logic [3:0] OP_RTI  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_LDI  = 4'd10;
  localparam logic [3:0] OP_STI  = 4'd11;
  localparam logic [3:0] OP_JMP  = 4'd12;
  localparam logic [3:0] OP_RES  = 4'd13;
  localparam logic [3:0] OP_LEA  = 4'd14;
  localparam logic [3:0] OP_TRAP = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dec_state_t;

endpackage

// File: rtl/sext.sv
// Sign-extends a WIDTH-bit field to 16 bits by replicating its MSB.
module sext #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] field,
  output logic [15:0]      ext
);

  assign ext = {{(16 - WIDTH){field[WIDTH-1]}}, field};

endmodule

// File: rtl/decode.sv
// LC-3 decode stage: captures instr_in MEM_LATENCY edges after decode_start, then
// splits the IR into fields; a start arriving while waiting on memory is dropped.
module decode
  import lc3_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        decode_start,
  input  logic [15:0] instr_in,
  output logic        busy,
  output logic        decode_done,
  output logic [15:0] ir,
  output logic [3:0]  opcode_out,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic        imm_flag,
  output logic [15:0] imm5_sext,
  output logic [15:0] offset6_sext,
  output logic [8:0]  offset_out,
  output logic [15:0] offset11_sext,
  output logic [2:0]  br_nzp_out,
  output logic        illegal_op
);

  localparam logic [2:0] LAST_COUNT = 3'(MEM_LATENCY - 1);

  dec_state_t state;
  logic [2:0] counter;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      counter     <= 3'd0;
      ir          <= 16'h0000;
      busy        <= 1'b0;
      decode_done <= 1'b0;
    end else begin
      decode_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (decode_start) begin
            state   <= ST_WAIT;
            counter <= 3'd0;
            busy    <= 1'b1;
          end
        end
        ST_WAIT: begin
          // decode_start is deliberately not looked at here: no queueing, no restart
          if (counter == LAST_COUNT) begin
            ir          <= instr_in;
            decode_done <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            counter <= counter + 3'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign opcode_out = ir[15:12];
  assign dr         = ir[11:9];
  assign sr1        = ir[8:6];
  assign sr2        = ir[2:0];
  assign imm_flag   = ir[5];
  assign offset_out = ir[8:0];
  assign br_nzp_out = ir[11:9];
  assign illegal_op = (ir[15:12] == OP_RES) || (ir[15:12] == OP_RTI);

  sext #(.WIDTH(5))  u_sext_imm5     (.field(ir[4:0]),  .ext(imm5_sext));
  sext #(.WIDTH(6))  u_sext_offset6  (.field(ir[5:0]),  .ext(offset6_sext));
  sext #(.WIDTH(11)) u_sext_offset11 (.field(ir[10:0]), .ext(offset11_sext));

endmodule
